shift_sequencer: RTL
====================

Name: shift_sequencer

Overview:
Sequential front/back end for the 4-bit combinational barrel shifter (datos/shift/operation -> salida). It accepts a shift command with a total amount of 0-15 through a valid/ready handshake. It drives the shifter in passes of at most 3 positions, registering the shifter output between passes. The final word is presented on a valid/ready output port, so a single 2-bit-amount shifter serves arbitrary 4-bit amounts.

Parameters:
WIDTH, 4, data width; fixed to match the shifter's datos/salida width.
AMT_W, 4, width of the requested total shift amount.
CNT_W, 3, width of the pass counter; holds a maximum of 5 passes.

Ports:
clk  input  1  system clock; the single clock domain
rst  input  1  reset; asynchronous, active-high
in_valid  input  1  command valid
in_ready  output  1  command accepted when in_valid && in_ready
in_data  input  WIDTH  operand
in_amount  input  AMT_W  total shift amount, 0-15
in_rotate  input  1  1 = rotate left, 0 = logical shift left with zero fill
bs_datos  output  WIDTH  to shifter datos
bs_shift  output  2  to shifter shift
bs_operation  output  1  to shifter operation
bs_salida  input  WIDTH  from shifter salida; combinational return path
out_valid  output  1  result valid
out_ready  input  1  result consumed when out_valid && out_ready
out_data  output  WIDTH  result word
out_passes  output  CNT_W  number of shifter passes used for this result
busy  output  1  high in STEP or DONE

Behaviour:
- Clocking and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset state:
  - state = IDLE.
  - work, rem, op and passes registers = 0.
  - in_ready = 1, out_valid = 0, out_data = 0, out_passes = 0, busy = 0.
  - bs_shift = 0, bs_operation = 0, bs_datos = 0.
- States: IDLE, STEP, DONE.
- IDLE:
  - in_ready = 1.
  - On handshake: work <= in_data, rem <= in_amount, op <= in_rotate, passes <= 0.
  - Next state = DONE if in_amount == 0, else STEP.
- STEP:
  - in_ready = 0.
  - chunk = min(rem, 3); bs_shift = chunk.
  - work <= bs_salida; rem <= rem - chunk; passes <= passes + 1.
  - Next state = DONE when rem - chunk == 0, else stay in STEP.
- DONE:
  - out_valid = 1, out_data = work, out_passes = passes.
  - All held stable until out_ready; on handshake, next state = IDLE.
  - in_ready stays 0 during the handshake cycle. A new command is accepted no earlier than the cycle after return to IDLE.
- Shifter drive (combinational from registers):
  - bs_datos = work and bs_operation = op in all states.
  - bs_shift = chunk in STEP, 0 otherwise.
- Pass count: ceil(in_amount / 3); 15 -> 5 passes, 4 -> 2 passes (3 then 1).
- Latency, with the command accepted at edge T:
  - amount 0: out_valid at T+1.
  - otherwise: out_valid at T + passes + 1.
  - With out_ready tied high, throughput is one command per passes + 2 cycles.
- Arithmetic:
  - Rotate result = in_data rotated left by (in_amount mod 4).
  - Logical shift result = in_data << in_amount, truncated to WIDTH; any amount >= 4 gives 0.
  - There is no early termination: passes are always ceil(amount / 3), even when work is already 0.
- Backpressure: out_data and out_passes are held stable while out_valid && !out_ready.
- in_valid while busy: ignored. The command is not latched; the upstream must hold it until in_ready.
- Reset mid-operation: rst asserted in STEP or DONE returns to IDLE immediately. The pending result is discarded and out_valid drops asynchronously.
- No X propagation: outputs are defined in every state.

Test Plan:
1. Reset, then command data=1011, amount=5, rotate=1 -> 2 passes (bs_shift 3 then 2); out_data=0111, out_passes=2; out_valid 3 cycles after accept.
2. data=1011, amount=2, rotate=0 -> 1 pass; out_data=1100, out_passes=1. Same data with amount=4, rotate=0 -> out_data=0000, out_passes=2.
3. data=1001, amount=0, rotate=1 -> out_data=1001, out_passes=0, out_valid at T+1; bs_shift stays 0 throughout.
4. data=0001, amount=15, rotate=1 -> bs_shift sequence 3,3,3,3,3; out_data=1000, out_passes=5. Hold out_ready=0 for 4 cycles -> out_data stable, in_ready=0, a new in_valid is ignored.
5. Back-to-back commands with out_ready=1: the second command is accepted only after return to IDLE, and both results are correct and in order.
6. Assert rst during the 3rd pass of an amount=15 command -> immediate IDLE, out_valid=0, in_ready=1; the next command completes correctly.

Source files
------------

// File: rtl/shift_sequencer.sv
// rtl/shift_sequencer.sv - multi-pass sequencer driving a 2-bit-amount barrel shifter
module shift_sequencer #(
    parameter int WIDTH = 4,
    parameter int AMT_W = 4,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [AMT_W-1:0] in_amount,
    input  logic             in_rotate,
    output logic [WIDTH-1:0] bs_datos,
    output logic [1:0]       bs_shift,
    output logic             bs_operation,
    input  logic [WIDTH-1:0] bs_salida,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] out_passes,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        STEP = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_work;
    logic [AMT_W-1:0] r_rem;
    logic             r_op;
    logic [CNT_W-1:0] r_passes;

    logic [1:0]       w_chunk;
    logic [AMT_W-1:0] w_rem_next;
    logic             w_accept;

    // The shifter moves at most 3 positions per pass; the last pass takes the remainder.
    assign w_chunk    = (r_rem > AMT_W'(3)) ? 2'd3 : r_rem[1:0];
    assign w_rem_next = r_rem - {{(AMT_W-2){1'b0}}, w_chunk};
    assign w_accept   = (r_state == IDLE) && in_valid;

    assign bs_datos     = r_work;
    assign bs_operation = r_op;

    // State register; reset abandons any command in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Datapath: latch the command, then fold one shifter pass into work per STEP cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_work   <= '0;
            r_rem    <= '0;
            r_op     <= 1'b0;
            r_passes <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_work   <= in_data;
                        r_rem    <= in_amount;
                        r_op     <= in_rotate;
                        r_passes <= '0;
                    end
                end
                STEP: begin
                    r_work   <= bs_salida;
                    r_rem    <= w_rem_next;
                    r_passes <= r_passes + CNT_W'(1);
                end
                default: begin
                end
            endcase
        end
    end

    // Next-state and handshake outputs; result outputs are zero outside DONE.
    always_comb begin
        w_next     = r_state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        out_data   = '0;
        out_passes = '0;
        busy       = 1'b0;
        bs_shift   = 2'd0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (w_accept) begin
                    w_next = (in_amount == '0) ? DONE : STEP;
                end
            end
            STEP: begin
                busy     = 1'b1;
                bs_shift = w_chunk;
                if (w_rem_next == '0) begin
                    w_next = DONE;
                end
            end
            DONE: begin
                busy       = 1'b1;
                out_valid  = 1'b1;
                out_data   = r_work;
                out_passes = r_passes;
                if (out_ready) begin
                    w_next = IDLE;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

endmodule
